// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: round-robin owner arbitration of the shared SD SPI command engine; watchdog enabled by SD_ARB_TIMEOUT_EN
module sd_spi_arbiter #(
  parameter int N_REQ = 3,
  parameter int CMD_W = 48,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*CMD_W-1:0] cmd,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [7:0]             resp,
  output logic                   err,
  output logic                   eng_start,
  output logic [CMD_W-1:0]       eng_cmd,
  input  logic                   eng_done,
  input  logic [7:0]             eng_resp,
  output logic                   eng_abort,
  output logic                   cs_n
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP, HOLD} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_owner, r_rr, w_win;
  logic [N_REQ-1:0] w_elig;
  logic [7:0] r_resp;
  logic r_err;
  logic [CMD_W-1:0] r_cmd;
  logic w_expire;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N_REQ);
  endfunction
  assign w_elig = req & (init_done ? {N_REQ{1'b1}} : N_REQ'(1));
  always_comb begin
    w_win = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (w_elig[wrap(int'(r_rr) + j)]) w_win = wrap(int'(r_rr) + j);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |w_elig ? GRANT : IDLE;
      GRANT:   w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (eng_done || w_expire) ? RESP : WAIT;
      RESP:    w_next = (lock[r_owner] && !r_err) ? HOLD : IDLE;
      HOLD:    w_next = req[r_owner] ? ISSUE : !lock[r_owner] ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
`ifdef SD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || r_state == ISSUE) r_cnt <= '0;
    else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
  // a completion arriving on the expiry cycle takes precedence over the abort
  assign w_expire = r_state == WAIT && !eng_done && r_cnt == CW'(TIMEOUT - 1);
`else
  assign w_expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_resp  <= 8'hFF;
      r_err   <= 1'b0;
      r_cmd   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_elig) begin
        r_owner <= w_win;
        if (init_done) r_rr <= wrap(int'(w_win) + 1);
      end
      if (w_next == ISSUE) r_cmd <= cmd[r_owner*CMD_W +: CMD_W];
      if (r_state == WAIT && (eng_done || w_expire)) begin
        r_resp <= eng_done ? eng_resp : 8'hFF;
        r_err  <= !eng_done;
      end
    end
  end
  assign gnt       = r_state == IDLE ? '0 : N_REQ'(1) << r_owner;
  assign ack       = r_state == RESP ? N_REQ'(1) << r_owner : '0;
  assign cs_n      = r_state == IDLE;
  assign eng_start = r_state == ISSUE;
  assign eng_cmd   = r_cmd;
  assign eng_abort = w_expire;
  assign resp      = r_resp;
  assign err       = r_err;
endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb_sd_spi_arbiter: timeline-model self-checking bench for sd_spi_arbiter
module tb_sd_spi_arbiter;
  localparam int N = 3, W = 48, TO = 16, MAXC = 1024;
  logic clk = 1'b0, rst = 1'b1, init_done = 1'b0, eng_done = 1'b0;
  logic [N-1:0] req = '0, lock = '0, gnt, ack;
  logic [N*W-1:0] cmd = '0;
  logic [7:0] resp, eng_resp = 8'h00;
  logic err, eng_start, eng_abort, cs_n;
  logic [W-1:0] eng_cmd;
  int cyc = 0, n_run = 0, n_fail = 0, rr = 0;
  bit chk_en = 1'b0, fall_mid = 1'b0;
  logic [N-1:0] e_gnt [MAXC], e_ack [MAXC];
  logic [7:0] e_resp [MAXC];
  logic e_err [MAXC], e_start [MAXC], e_abort [MAXC], e_csn [MAXC];
  logic [W-1:0] e_cmd [MAXC];
  logic [N-1:0] rr_exp [6] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};
  sd_spi_arbiter #(.N_REQ(N), .CMD_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req), .lock(lock), .cmd(cmd),
    .gnt(gnt), .ack(ack), .resp(resp), .err(err), .eng_start(eng_start), .eng_cmd(eng_cmd),
    .eng_done(eng_done), .eng_resp(eng_resp), .eng_abort(eng_abort), .cs_n(cs_n)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_run++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, ex);
    end
  endtask
  always @(negedge clk)
    if (chk_en && cyc < MAXC) begin
      chk("gnt", 64'(gnt), 64'(e_gnt[cyc]));
      chk("ack", 64'(ack), 64'(e_ack[cyc]));
      chk("resp", 64'(resp), 64'(e_resp[cyc]));
      chk("err", 64'(err), 64'(e_err[cyc]));
      chk("eng_start", 64'(eng_start), 64'(e_start[cyc]));
      chk("eng_abort", 64'(eng_abort), 64'(e_abort[cyc]));
      chk("cs_n", 64'(cs_n), 64'(e_csn[cyc]));
      chk("eng_cmd", 64'(eng_cmd), 64'(e_cmd[cyc]));
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic fill_own(input int from, input int w);
    for (int i = from; i < MAXC; i++) begin
      e_gnt[i] = N'(1) << w;
      e_csn[i] = 1'b0;
    end
  endtask
  task automatic fill_rel(input int from);
    for (int i = from; i < MAXC; i++) begin
      e_gnt[i] = '0;
      e_csn[i] = 1'b1;
    end
  endtask
  task automatic fill_resp(input int from, input logic [7:0] r, input logic e);
    for (int i = from; i < MAXC; i++) begin
      e_resp[i] = r;
      e_err[i] = e;
    end
  endtask
  task automatic fill_cmd(input int from, input logic [W-1:0] c);
    for (int i = from; i < MAXC; i++) e_cmd[i] = c;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int i = cyc + 1; i < MAXC; i++) begin
      e_gnt[i] = '0; e_ack[i] = '0; e_resp[i] = 8'hFF; e_err[i] = 1'b0;
      e_start[i] = 1'b0; e_abort[i] = 1'b0; e_csn[i] = 1'b1; e_cmd[i] = '0;
    end
    rr = 0;
    step();
    step();
    rst = 1'b0;
  endtask
  function automatic int pick();
    if (!init_done) return 0;
    for (int j = 0; j < N; j++) begin
      int k = (rr + j) % N;
      if ((req >> k) & N'(1)) return k;
    end
    return 0;
  endfunction
  task automatic serve(input int s, input int w, input int dly, input logic [7:0] r, input bit keep);
    int k = s + dly;
    e_start[s] = 1'b1;
    fill_cmd(s, cmd[w*W +: W]);
    e_ack[k+1] = N'(1) << w;
    fill_resp(k + 1, r, 1'b0);
    if (!keep) fill_rel(k + 2);
    go_to(s + 1);
    if (fall_mid) begin
      init_done = 1'b0;
      req = 3'b011;
      fall_mid = 1'b0;
    end
    go_to(k);
    eng_done = 1'b1;
    eng_resp = r;
    step();
    eng_done = 1'b0;
    eng_resp = 8'h00;
  endtask
  task automatic expire(input int s, input int w);
    e_start[s] = 1'b1;
    fill_cmd(s, cmd[w*W +: W]);
    e_abort[s+TO] = 1'b1;
    e_ack[s+TO+1] = N'(1) << w;
    fill_resp(s + TO + 1, 8'hFF, 1'b1);
    fill_rel(s + TO + 2);
    go_to(s + TO + 1);
  endtask
  task automatic grant(input int dly, input logic [7:0] r, input bit keep, input bit tmo, output int w);
    w = pick();
    if (init_done) rr = (w + 1) % N;
    fill_own(cyc + 1, w);
    if (tmo) expire(cyc + 2, w);
    else serve(cyc + 2, w, dly, r, keep);
  endtask
  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    do_reset();
    chk_en = 1'b1;
    chk("reset resp", 64'(resp), 64'h FF);
    chk("reset cs_n", 64'(cs_n), 64'h1);
    chk("reset gnt", 64'(gnt), 64'h0);
    cmd = {48'h58_0000_0200_FF, 48'h51_0000_0000_55, 48'h40_0000_0000_95};
    init_done = 1'b0;
    req = 3'b111;
    grant(10, 8'h01, 1'b0, 1'b0, w);
    chk("t1 ack", 64'(ack), 64'h1);
    chk("t1 resp", 64'(resp), 64'h01);
    req = '0;
    step();
    chk("t1 release", 64'(cs_n), 64'h1);
    cmd[0 +: W] = 48'h77_0000_0000_65;
    req = 3'b001;
    lock = 3'b001;
    grant(5, 8'h01, 1'b1, 1'b0, w);
    req = '0;
    step();
    chk("t2 hold cs_n", 64'(cs_n), 64'h0);
    chk("t2 hold gnt", 64'(gnt), 64'h1);
    eng_done = 1'b1;
    eng_resp = 8'h55;
    req = 3'b010;
    step();
    eng_done = 1'b0;
    eng_resp = 8'h00;
    step();
    cmd[0 +: W] = 48'h69_4000_0000_77;
    req = 3'b001;
    serve(cyc + 1, 0, 3, 8'h00, 1'b1);
    chk("t2 ack2", 64'(ack), 64'h1);
    chk("t2 resp2", 64'(resp), 64'h00);
    req = '0;
    step();
    lock = '0;
    fill_rel(cyc + 1);
    step();
    chk("t2 release", 64'(cs_n), 64'h1);
    init_done = 1'b1;
    req = 3'b110;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req = 3'b111;
      grant(i + 1, 8'(8'h10 + i), 1'b0, 1'b0, w);
      chk("t3 rr order", 64'(ack), 64'(rr_exp[i]));
      if (i == 5) req = '0;
      step();
    end
    req = 3'b010;
    fall_mid = 1'b1;
    grant(4, 8'h22, 1'b0, 1'b0, w);
    chk("t4 inflight ack", 64'(ack), 64'h2);
    step();
    grant(2, 8'h05, 1'b0, 1'b0, w);
    chk("t4 masked ack", 64'(ack), 64'h1);
    req = '0;
    step();
    init_done = 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
    req = 3'b001;
    lock = 3'b001;
    grant(0, 8'h00, 1'b1, 1'b1, w);
    chk("t5 err", 64'(err), 64'h1);
    chk("t5 resp", 64'(resp), 64'hFF);
    req = '0;
    step();
    chk("t5 forced release", 64'(cs_n), 64'h1);
    req = 3'b001;
    grant(TO, 8'h3C, 1'b1, 1'b0, w);
    chk("t5b err", 64'(err), 64'h0);
    chk("t5b resp", 64'(resp), 64'h3C);
    req = '0;
    step();
    lock = '0;
    fill_rel(cyc + 1);
    step();
`endif
    req = 3'b010;
    w = pick();
    rr = (w + 1) % N;
    fill_own(cyc + 1, w);
    e_start[cyc+2] = 1'b1;
    fill_cmd(cyc + 2, cmd[w*W +: W]);
    go_to(cyc + 4);
    req = '0;
    do_reset();
    chk("t6 gnt", 64'(gnt), 64'h0);
    chk("t6 cs_n", 64'(cs_n), 64'h1);
    chk("t6 resp", 64'(resp), 64'hFF);
    chk("t6 ack", 64'(ack), 64'h0);
    req = 3'b111;
    grant(4, 8'hA5, 1'b0, 1'b0, w);
    chk("t6 rr reset", 64'(ack), 64'h1);
    req = '0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_spi_arbiter.md
# sd_spi_arbiter

Shares the single SPI command/byte engine of the SD card controller among several requesters: the init sequencer, block-read engine and block-write engine. Grants one owner at a time, forwards its 48-bit command frame to the engine and returns the R1 response. Holds ownership and chip-select across multi-command sequences such as CMD55+ACMD41 and CMD17+data. Sits between the requester FSMs and the SPI engine inside the SD top level.

## Interface
- N_REQ, 3, number of requesters; index 0 is the init sequencer
- CMD_W, 48, command frame width (start, index, argument, CRC, stop)
- TIMEOUT, 4096, engine watchdog limit in clk cycles (min 2)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- init_done  in  1  0: only req[0] eligible; 1: all eligible
- req  in  N_REQ  per-requester command request, level
- lock  in  N_REQ  owner keeps grant after ack
- cmd  in  N_REQ*CMD_W  packed frames; requester i at [i*CMD_W +: CMD_W]
- gnt  out  N_REQ  one-hot current owner
- ack  out  N_REQ  one-cycle pulse to owner; resp/err valid
- resp  out  8  R1 response byte
- err  out  1  transaction timed out
- eng_start  out  1  one-cycle engine start pulse
- eng_cmd  out  CMD_W  frame to engine, stable from eng_start to eng_done
- eng_done  in  1  engine completion pulse
- eng_resp  in  8  engine response, valid with eng_done
- eng_abort  out  1  one-cycle abort pulse to engine
- cs_n  out  1  SD chip select, low while any grant held

## Operation
- States: IDLE, GRANT, ISSUE, WAIT, RESP, HOLD.
- IDLE: eligible = req masked by init_done (bit 0 only when init_done=0). Eligible nonzero -> latch winner, GRANT.
- Arbitration is round-robin from pointer rr; winner is the first eligible index at or above rr, wrapping. On grant, rr = (winner+1) mod N_REQ. When init_done=0, req[0] wins regardless of rr, and rr is not updated.
- GRANT: gnt one-hot and cs_n=0 registered; -> ISSUE.
- ISSUE: eng_cmd = cmd slice of owner, eng_start=1 for one cycle; -> WAIT.
- WAIT: stay until eng_done; latch eng_resp; -> RESP.
- RESP: ack[owner]=1 one cycle, resp and err driven. Then -> HOLD if lock[owner]=1, else IDLE with gnt=0 and cs_n=1.
- HOLD: gnt and cs_n held. req[owner]=1 -> ISSUE with a new command. lock[owner]=0 -> IDLE, release. Other requesters are ignored.
- Requester rule: req[owner] sampled during the RESP cycle is ignored. req high in HOLD is a new command, so the requester deasserts req on seeing ack.
- resp and err hold their values until the next RESP.

## Timing
- Reset values: gnt=0, ack=0, resp=8'hFF, err=0, eng_start=0, eng_cmd=0, eng_abort=0, cs_n=1, rr=0, state IDLE.
- Cycle sequence:
  - req rises in IDLE at cycle 0.
  - gnt and cs_n=0 at cycle 1.
  - eng_start at cycle 2.
  - eng_done at cycle k.
  - ack at cycle k+1.
  - Release (cs_n=1) at cycle k+2 when lock=0.
- Back-to-back locked command: req in HOLD at cycle h -> eng_start at h+1.
- An eng_done outside WAIT is ignored.
- init_done falling mid-transaction: current transaction completes; the mask applies at the next IDLE arbitration.
- rst mid-transaction: all outputs take reset values next cycle. No eng_abort is issued; the engine shares rst.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A counter clears on eng_start and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 without eng_done: eng_abort pulses one cycle and the state goes to RESP with resp=8'hFF, err=1.
  - After that ack, the block always releases to IDLE, ignoring lock.
  - eng_done in the same cycle as expiry wins: normal response, err=0, no abort.
- SD_ARB_TIMEOUT_EN undefined: WAIT is unbounded, with no counter. err and eng_abort are tied 0.

## Test plan
- Reset, then init_done=0, req=3'b111: only requester 0 granted. eng_cmd = cmd0, eng_start at cycle 2. Engine returns done with resp 8'h01 after 10 cycles -> ack=3'b001 with resp=8'h01, cs_n=1 two cycles later.
- Locked sequence: requester 0 holds lock=1 and sends CMD55 then ACMD41 (48'h77...,48'h69...). cs_n stays low across both, with two ack pulses. lock=0 after the second ack -> cs_n=1 next cycle.
- init_done=1, req=3'b110 held continuously: grants alternate 1,2,1,2. Raise req[0] -> the order follows rr wrap (0 after 2).
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT=16): engine never completes -> eng_abort pulse 16 cycles after eng_start, ack with resp=8'hFF, err=1, release despite lock=1. Repeat with eng_done on the expiry cycle -> err=0, no abort.
- Assert rst during WAIT: next cycle gnt=0, cs_n=1, resp=8'hFF, no ack. A new req is then served normally with rr=0.
